// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store.
// Ports: clk/rst, if_* fetch side, ls_* data side, mem_* port, stall_F/M, bus_err.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_F,
  output logic        stall_M,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    LS_BUSY = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  streak;
  logic [4:0]  tmo;
  logic        discard;
  logic        busy;
  logic        expire;
  logic        ack_any;
  logic        grant_ls;
  logic        grant_if;
  logic        done;
  logic        drop;
  logic        starve;

  assign busy    = (state != IDLE);
  assign expire  = busy && !mem_ack && (tmo == 5'(TIMEOUT - 1));
  // The requester still holds its request during its ack cycle,
  // so nothing is granted then to avoid serving it twice.
  assign ack_any = if_ack | ls_ack;
  assign starve  = if_req && (streak == 3'(MAX_STREAK));
  assign drop    = discard | if_flush;

  assign stall_F = if_req & ~if_ack;
  assign stall_M = ls_req & ~ls_ack;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ack_any) begin
          if (ls_req && !starve) begin
            grant_ls = 1'b1;
            state_nx = LS_BUSY;
          end else if (if_req) begin
            grant_if = 1'b1;
            state_nx = IF_BUSY;
          end
        end
      end
      IF_BUSY, LS_BUSY: begin
        if (mem_ack || expire) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else if (grant_ls) begin
      mem_req   <= 1'b1;
      mem_we    <= ls_we;
      mem_be    <= ls_be;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
    end else if (grant_if) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_be    <= 4'hF;
      mem_addr  <= if_addr;
    end else if (done) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_ack   <= 1'b0;
      ls_ack   <= 1'b0;
      bus_err  <= 1'b0;
      if_rdata <= 32'h0;
      ls_rdata <= 32'h0;
    end else begin
      if_ack  <= 1'b0;
      ls_ack  <= 1'b0;
      bus_err <= 1'b0;
      if (done && state == LS_BUSY) begin
        ls_ack  <= 1'b1;
        bus_err <= expire;
        if (expire)
          ls_rdata <= 32'h0;
        else if (!mem_we)
          ls_rdata <= mem_rdata;
      end
      // A flushed fetch finishes silently.
      if (done && state == IF_BUSY && !drop) begin
        if_ack   <= 1'b1;
        bus_err  <= expire;
        if_rdata <= expire ? 32'h0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo     <= 5'd0;
      discard <= 1'b0;
      streak  <= 3'd0;
    end else begin
      if (grant_ls || grant_if) tmo <= 5'd0;
      else if (busy)            tmo <= tmo + 5'd1;

      if (state == IDLE)
        discard <= 1'b0;
      else if (state == IF_BUSY && if_flush)
        discard <= 1'b1;

      if (!if_req || grant_if)
        streak <= 3'd0;
      else if (grant_ls && streak != 3'(MAX_STREAK))
        streak <= streak + 3'd1;
    end
  end

endmodule
